// File: rtl/rvvi_trace_gen_pkg.sv
// Shared types and constants for the RVVI trace producer.
// Record layout, trace version and register-count selection.
package rvvi_trace_pkg;

    localparam int RVVI_TRACE_VERSION_MAJOR = 1;
    localparam int RVVI_TRACE_VERSION_MINOR = 5;

    localparam int RVVI_XLEN = 32;
    localparam int RVVI_ILEN = 32;

`ifdef COVER_E
    localparam int RVVI_NUM_REGS = 16;
`else
    localparam int RVVI_NUM_REGS = 32;
`endif

    typedef struct packed {
        logic [RVVI_ILEN-1:0] insn;
        logic [RVVI_XLEN-1:0] pc;
        logic [RVVI_XLEN-1:0] next_pc;
        logic                 trap;
        logic [1:0]           mode;
        logic                 rd_wen;
        logic [4:0]           rd;
        logic [RVVI_XLEN-1:0] rd_data;
        logic                 csr_wen;
        logic [11:0]          csr_addr;
        logic [RVVI_XLEN-1:0] csr_data;
    } retire_rec_t;

endpackage

// File: rtl/rvvi_trace_gen_if.sv
// Retire-side inputs and RVVI event outputs of the trace producer.
// master: the producer; slave: the core/consumer side.
interface rvvi_trace_gen_if
    import rvvi_trace_pkg::*;
#(
    parameter int XLEN     = RVVI_XLEN,
    parameter int ILEN     = RVVI_ILEN,
    parameter int NUM_REGS = RVVI_NUM_REGS
);
    logic                     ret_valid;
    logic [ILEN-1:0]          ret_insn;
    logic [XLEN-1:0]          ret_pc;
    logic [XLEN-1:0]          ret_next_pc;
    logic                     ret_trap;
    logic [1:0]               ret_mode;
    logic                     ret_rd_wen;
    logic [4:0]               ret_rd;
    logic [XLEN-1:0]          ret_rd_data;
    logic                     ret_csr_wen;
    logic [11:0]              ret_csr_addr;
    logic [XLEN-1:0]          ret_csr_data;
    logic                     out_ready;

    logic                     valid;
    logic [63:0]              order;
    logic [ILEN-1:0]          insn;
    logic                     trap;
    logic [XLEN-1:0]          pc_rdata;
    logic [XLEN-1:0]          pc_wdata;
    logic [1:0]               mode;
    logic [NUM_REGS*XLEN-1:0] x_wdata;
    logic [NUM_REGS-1:0]      x_wb;
    logic                     csr_wb_en;
    logic [11:0]              csr_wb_addr;
    logic [XLEN-1:0]          csr_wb_data;
    logic                     overflow;

    modport master (
        input  ret_valid, ret_insn, ret_pc, ret_next_pc,
        input  ret_trap, ret_mode, ret_rd_wen, ret_rd,
        input  ret_rd_data, ret_csr_wen, ret_csr_addr,
        input  ret_csr_data, out_ready,
        output valid, order, insn, trap, pc_rdata,
        output pc_wdata, mode, x_wdata, x_wb,
        output csr_wb_en, csr_wb_addr, csr_wb_data,
        output overflow
    );

    modport slave (
        output ret_valid, ret_insn, ret_pc, ret_next_pc,
        output ret_trap, ret_mode, ret_rd_wen, ret_rd,
        output ret_rd_data, ret_csr_wen, ret_csr_addr,
        output ret_csr_data, out_ready,
        input  valid, order, insn, trap, pc_rdata,
        input  pc_wdata, mode, x_wdata, x_wb,
        input  csr_wb_en, csr_wb_addr, csr_wb_data,
        input  overflow
    );

endinterface

// File: rtl/rvvi_trace_gen_fifo.sv
// Retire-record FIFO with MSB-compare full/empty pointers.
// A push while full is taken only if a pop frees a slot that cycle.
module rvvi_trace_fifo
    import rvvi_trace_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type rec_t = retire_rec_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  rec_t din,
    output logic full,
    output logic empty,
    output rec_t head
);
    localparam int AW = $clog2(DEPTH);

    rec_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rvvi_trace_gen.sv
// RVVI trace producer: retire FIFO, output stage, shadow GPRs,
// event order counter and sticky overflow flag.
module rvvi_trace_gen
    import rvvi_trace_pkg::*;
#(
    parameter int XLEN     = RVVI_XLEN,
    parameter int ILEN     = RVVI_ILEN,
    parameter int NUM_REGS = RVVI_NUM_REGS,
    parameter int DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    rvvi_trace_gen_if.master tr
);
    typedef struct packed {
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
        logic            trap;
        logic [1:0]      mode;
        logic            rd_wen;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic            csr_wen;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_data;
    } rec_t;

    rec_t                     in_rec;
    rec_t                     head;
    logic                     full;
    logic                     empty;
    logic                     load;
    logic [63:0]              order_cnt;
    logic [NUM_REGS-1:0]      hot;
    logic [NUM_REGS*XLEN-1:0] xfile;

    assign in_rec = '{
        insn:     tr.ret_insn,
        pc:       tr.ret_pc,
        next_pc:  tr.ret_next_pc,
        trap:     tr.ret_trap,
        mode:     tr.ret_mode,
        rd_wen:   tr.ret_rd_wen,
        rd:       tr.ret_rd,
        rd_data:  tr.ret_rd_data,
        csr_wen:  tr.ret_csr_wen,
        csr_addr: tr.ret_csr_addr,
        csr_data: tr.ret_csr_data
    };

    // Refill when empty or when the current event is taken.
    assign load = !empty && (!tr.valid || tr.out_ready);

    rvvi_trace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tr.ret_valid),
        .pop   (load),
        .din   (in_rec),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // x0 and registers beyond NUM_REGS never get a flag.
    always_comb begin
        hot = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            hot[i] = head.rd_wen && !head.trap && (head.rd == 5'(i));
        end
    end

    assign tr.x_wdata = xfile;

    always_ff @(posedge clk) begin
        if (reset) begin
            tr.valid       <= 1'b0;
            tr.order       <= '0;
            tr.insn        <= '0;
            tr.trap        <= 1'b0;
            tr.pc_rdata    <= '0;
            tr.pc_wdata    <= '0;
            tr.mode        <= 2'b11;
            tr.x_wb        <= '0;
            tr.csr_wb_en   <= 1'b0;
            tr.csr_wb_addr <= '0;
            tr.csr_wb_data <= '0;
            tr.overflow    <= 1'b0;
            order_cnt      <= '0;
            xfile          <= '0;
        end else begin
            if (tr.ret_valid && full && !load) tr.overflow <= 1'b1;
            if (load) begin
                tr.valid       <= 1'b1;
                tr.order       <= order_cnt;
                order_cnt      <= order_cnt + 64'd1;
                tr.insn        <= head.insn;
                tr.trap        <= head.trap;
                tr.pc_rdata    <= head.pc;
                tr.pc_wdata    <= head.next_pc;
                tr.mode        <= head.mode;
                tr.x_wb        <= hot;
                tr.csr_wb_en   <= head.csr_wen;
                tr.csr_wb_addr <= head.csr_addr;
                tr.csr_wb_data <= head.csr_data;
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (hot[i]) xfile[i*XLEN +: XLEN] <= head.rd_data;
                end
            end else if (tr.valid && tr.out_ready) begin
                tr.valid     <= 1'b0;
                tr.x_wb      <= '0;
                tr.csr_wb_en <= 1'b0;
            end
        end
    end

endmodule
